// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences the shared memory, IR, register file, ALU and PC through fetch,
// decode, execute, memory and writeback states. Memory states stall on
// mem_ready, and every completed instruction bumps retired_count.
// Ports: clk, rst (async, active high); opcode, zero and mem_ready in;
// datapath strobes and selects, state (debug), retired, illegal_op and
// retired_count out.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_EN = 1,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state,
  output logic                retired,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retired;
    logic       illegal_op;
  } ctl_t;

  state_t cur;
  state_t nxt;
  ctl_t   c;
  ctl_t   o;
  logic   rdy;

  // zero only steers the PC through pc_write_cond in the datapath.
  logic   unused_zero;
  assign unused_zero = zero;

  assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= S_FETCH;
      retired_count <= '0;
    end else begin
      cur <= nxt;
      if (c.retired)
        retired_count <= retired_count + RETIRE_W'(1);
    end
  end

  always_comb begin
    nxt = cur;
    c   = '0;
    case (cur)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        if (rdy) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        case (opcode)
          OP_R:         nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            c.illegal_op = 1'b1;
            nxt          = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (rdy)
          nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retired    = 1'b1;
        nxt          = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (rdy) begin
          c.retired = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.retired   = 1'b1;
        nxt         = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.retired       = 1'b1;
        nxt             = S_FETCH;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        nxt         = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.retired   = 1'b1;
        nxt         = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.retired   = 1'b1;
        nxt         = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset silences every output at once, so an aborted instruction
  // never issues a strobe or a retire pulse.
  assign o = rst ? '0 : c;

  assign pc_write      = o.pc_write;
  assign pc_write_cond = o.pc_write_cond;
  assign i_or_d        = o.i_or_d;
  assign mem_read      = o.mem_read;
  assign mem_write     = o.mem_write;
  assign ir_write      = o.ir_write;
  assign mem_to_reg    = o.mem_to_reg;
  assign reg_dst       = o.reg_dst;
  assign reg_write     = o.reg_write;
  assign alu_src_a     = o.alu_src_a;
  assign alu_src_b     = o.alu_src_b;
  assign alu_op        = o.alu_op;
  assign pc_source     = o.pc_source;
  assign retired       = o.retired;
  assign illegal_op    = o.illegal_op;
  assign state         = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table,
// hand sequences for wrap/abort/no-wait, and a randomized run vs a model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  always #5 clk = ~clk;

  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, retired, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [31:0] retired_count;

  logic a_pcw, a_pcc, a_iod, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_asa;
  logic a_ret, a_ill;
  logic [1:0] a_asb, a_aop, a_psrc;
  logic [3:0] a_state;
  logic [3:0] a_count;

  logic b_pcw, b_pcc, b_iod, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_asa;
  logic b_ret, b_ill;
  logic [1:0] b_asb, b_aop, b_psrc;
  logic [3:0] b_state;
  logic [31:0] b_count;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .retired(retired), .illegal_op(illegal_op),
    .retired_count(retired_count)
  );

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1), .RETIRE_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(a_pcw), .pc_write_cond(a_pcc),
    .i_or_d(a_iod), .mem_read(a_mr), .mem_write(a_mw),
    .ir_write(a_irw), .mem_to_reg(a_m2r), .reg_dst(a_rd),
    .reg_write(a_rw), .alu_src_a(a_asa),
    .alu_src_b(a_asb), .alu_op(a_aop), .pc_source(a_psrc),
    .state(a_state), .retired(a_ret), .illegal_op(a_ill),
    .retired_count(a_count)
  );

  mips_multicycle_ctrl #(.MEM_WAIT_EN(0), .RETIRE_W(32)) dutnw (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(1'b0),
    .pc_write(b_pcw), .pc_write_cond(b_pcc),
    .i_or_d(b_iod), .mem_read(b_mr), .mem_write(b_mw),
    .ir_write(b_irw), .mem_to_reg(b_m2r), .reg_dst(b_rd),
    .reg_write(b_rw), .alu_src_a(b_asa),
    .alu_src_b(b_asb), .alu_op(b_aop), .pc_source(b_psrc),
    .state(b_state), .retired(b_ret), .illegal_op(b_ill),
    .retired_count(b_count)
  );

  int checks = 0;
  int failures = 0;
  int excl_err = 0;

  always @(negedge clk)
    if ((mem_read & mem_write) | (a_mr & a_mw) | (b_mr & b_mw))
      excl_err++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs and the key outputs expected that cycle.
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic       zero;
    logic [3:0] st;
    logic       mr, mw, pcw, pcc;
    logic [1:0] psrc;
    logic       rw, rd, ret, ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input logic z, input logic [3:0] st,
                     input logic mr, input logic mw, input logic pcw,
                     input logic pcc, input logic [1:0] psrc,
                     input logic rw, input logic rd, input logic ret,
                     input logic ill);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.zero = z; v.st = st;
    v.mr = mr; v.mw = mw; v.pcw = pcw; v.pcc = pcc; v.psrc = psrc;
    v.rw = rw; v.rd = rd; v.ret = ret; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Control word expected in a given state, straight from the state table.
  typedef struct packed {
    logic       pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       ill;
  } ctl_t;

  function automatic ctl_t spec_ctl(input int st, input logic [5:0] op,
                                    input logic rdy);
    ctl_t e = '0;
    case (st)
      0: begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      1: begin
        e.asb = 2'b11;
        e.ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02});
      end
      2: begin e.asa = 1; e.asb = 2'b10; end
      3: begin e.mr = 1; e.iod = 1; end
      4: begin e.rw = 1; e.m2r = 1; end
      5: begin e.mw = 1; e.iod = 1; end
      6: begin e.asa = 1; e.aop = 2'b10; end
      7: begin e.rw = 1; e.rd = 1; end
      8: begin e.asa = 1; e.aop = 2'b01; e.pcc = 1; e.psrc = 2'b01; end
      9: begin e.asa = 1; e.asb = 2'b10; end
      10: e.rw = 1;
      11: begin e.pcw = 1; e.psrc = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Post-decode state route of each instruction class.
  int route[$];

  task automatic set_route(input logic [5:0] op);
    route.delete();
    case (op)
      6'h00: route = '{6, 7};
      6'h23: route = '{2, 3, 4};
      6'h2b: route = '{2, 5};
      6'h04: route = '{8};
      6'h08: route = '{9, 10};
      6'h02: route = '{11};
      default: route.delete();
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[7];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f};
    if ($urandom_range(0, 9) == 0)
      return 6'($urandom_range(0, 63));
    return ops[$urandom_range(0, 6)];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  int ms;
  logic [31:0] mcount;
  int nw_exp[5];

  initial begin
    // 1: reset, then R-type
    for (int i = 0; i < 3; i++)
      add(1, 6'h00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h00, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h00, 1, 0, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h00, 1, 0, 7, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0);
    // 2: lw with two stall cycles in MEMRD
    add(0, 6'h23, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 1, 0, 2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 1, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h23, 1, 0, 4, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0);
    // 3: beq taken, then j
    add(0, 6'h04, 1, 1, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h04, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h04, 1, 1, 8, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0);
    add(0, 6'h02, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h02, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h02, 1, 0, 11, 0, 0, 1, 0, 2'b10, 0, 0, 1, 0);
    // 4: illegal opcode
    add(0, 6'h3f, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h3f, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    add(0, 6'h3f, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 6'h3f, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      opcode = vecs[i].op;
      mem_ready = vecs[i].rdy;
      zero = vecs[i].zero;
      #1;
      chk($sformatf("vec%0d", i),
          {state, mem_read, mem_write, pc_write, pc_write_cond, pc_source,
           reg_write, reg_dst, retired, illegal_op},
          {vecs[i].st, vecs[i].mr, vecs[i].mw, vecs[i].pcw, vecs[i].pcc,
           vecs[i].psrc, vecs[i].rw, vecs[i].rd, vecs[i].ret, vecs[i].ill});
      if (vecs[i].rst)
        chk("reset_count", retired_count, 0);
    end
    @(negedge clk);
    #1;
    chk("count_after_table", retired_count, 4);

    // 5: 17 R-types wrap the 4-bit counter; reset aborts sw in MEMWR
    opcode = 6'h00;
    mem_ready = 1'b1;
    do_reset();
    repeat (68) @(posedge clk);
    #1;
    chk("wrap_count4", a_count, 1);
    chk("count32_17", retired_count, 17);
    @(negedge clk);
    opcode = 6'h2b;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sw_in_memwr", {state, mem_write, retired}, {4'd5, 1'b1, 1'b0});
    rst = 1'b1;
    #1;
    chk("abort_state", {state, mem_write, retired}, {4'd0, 1'b0, 1'b0});
    chk("abort_count", retired_count, 0);
    @(negedge clk);
    #1;
    chk("abort_hold", {state, retired, a_count}, {4'd0, 1'b0, 4'd0});

    // 6: no-wait build ignores mem_ready=0; sw takes 4 cycles
    opcode = 6'h2b;
    mem_ready = 1'b0;
    do_reset();
    nw_exp = '{0, 1, 2, 5, 0};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("nowait%0d", i), {b_state, b_ret},
          {4'(nw_exp[i]), 1'(i == 3)});
      @(negedge clk);
    end
    chk("nowait_count", b_count, 1);
    chk("main_stalled", state, 0);

    // Randomized run against the instruction-level model.
    do_reset();
    ms = 0;
    mcount = 0;
    route.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic ret;
      logic stall;
      ctl_t e;
      ctl_t a;
      if (cyc != 0) @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (ms == 0) opcode = pick_op();
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      #1;
      stall = (ms == 3 || ms == 5) && !mem_ready;
      if (rst) begin
        e = '0;
        ret = 1'b0;
      end else begin
        e = spec_ctl(ms, opcode, mem_ready);
        ret = (ms >= 2) && (route.size() == 0) && !stall;
      end
      a = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal_op};
      chk("rand_ctl", {state, retired, a},
          {(rst ? 4'd0 : 4'(ms)), ret, e});
      chk("rand_count", {a_count, retired_count},
          {(rst ? 4'd0 : mcount[3:0]), (rst ? 32'd0 : mcount)});
      if (rst) begin
        ms = 0;
        mcount = 0;
        route.delete();
      end else begin
        if (ret) mcount++;
        if (ms == 0) begin
          if (mem_ready) ms = 1;
        end else if (ms == 1) begin
          set_route(opcode);
          ms = (route.size() != 0) ? route.pop_front() : 0;
        end else if (!stall) begin
          ms = (route.size() != 0) ? route.pop_front() : 0;
        end
      end
    end

    @(negedge clk);
    chk("rd_wr_exclusive", excl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
